// File: rtl/reel_result_judge.sv
// Game-control stage around the reel scroll controller: gates starts against the
// credit balance, waits for the reels to settle, scores the line and pays out.
module reel_result_judge #(
  parameter int ROWS          = 240,
  parameter int SYM_H         = 80,
  parameter int SETTLE        = 4,
  parameter int ARM_TO        = 16,
  parameter int CREDIT_W      = 8,
  parameter int START_CREDITS = 10,
  parameter int BET           = 1,
  parameter int PAY3          = 8,
  parameter int PAY2          = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_req,
  input  logic                coin_in,
  input  logic [9:0]          a_pos,
  input  logic [9:0]          b_pos,
  input  logic [9:0]          c_pos,
  output logic                spin_go,
  output logic                busy,
  output logic [CREDIT_W-1:0] credits,
  output logic [1:0]          sym_a,
  output logic [1:0]          sym_b,
  output logic [1:0]          sym_c,
  output logic [CREDIT_W-1:0] payout,
  output logic                result_valid,
  output logic                win,
  output logic                no_credit,
  output logic [2:0]          state_dbg
);

  // Control strobes (start_req, coin_in in; spin_go, result_valid, win, no_credit out)
  // are single-cycle pulses without back-pressure, consumed on the edge that samples them.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPIN   = 3'd1,
    S_SETTLE = 3'd2,
    S_JUDGE  = 3'd3,
    S_PAY    = 3'd4
  } state_t;

  localparam int NSYM = ROWS / SYM_H;
  localparam int TO_W = $clog2(ARM_TO + 1);
  localparam int ST_W = $clog2(SETTLE + 1);
  localparam int SW   = CREDIT_W + 2;
  localparam logic [CREDIT_W-1:0] CMAX   = '1;
  localparam logic [CREDIT_W-1:0] BET_C  = CREDIT_W'(BET);
  localparam logic [CREDIT_W-1:0] PAY3_C = CREDIT_W'(PAY3);
  localparam logic [CREDIT_W-1:0] PAY2_C = CREDIT_W'(PAY2);
  localparam logic [CREDIT_W-1:0] START_C = CREDIT_W'(START_CREDITS);

  state_t              state_q, state_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [ST_W-1:0]     st_q, st_d;
  logic [9:0]          pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
  logic [CREDIT_W-1:0] credits_q, credits_d, payout_q, payout_d;
  logic [1:0]          sym_a_q, sym_a_d, sym_b_q, sym_b_d, sym_c_q, sym_c_d;
  logic                spin_go_q, spin_go_d, busy_q, busy_d;
  logic                result_valid_q, result_valid_d, win_q, win_d;
  logic                no_credit_q, no_credit_d;

  logic                moved;
  logic [1:0]          qa, qb, qc;
  logic [CREDIT_W-1:0] score, add, sub;
  logic [SW-1:0]       sum;

  // Compare chain against symbol boundaries; offsets past the strip land on the last symbol.
  function automatic logic [1:0] quant(input logic [9:0] pos);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 1; k < 4; k++) begin
      if (k < NSYM && int'(pos) >= k * SYM_H) idx = 2'(k);
    end
    return idx;
  endfunction

  always_comb begin
    moved = (a_pos != pa_q) || (b_pos != pb_q) || (c_pos != pc_q);
    qa = quant(a_pos);
    qb = quant(b_pos);
    qc = quant(c_pos);
    if (qa == qb && qb == qc)                  score = PAY3_C;
    else if (qa == qb || qb == qc || qa == qc) score = PAY2_C;
    else                                       score = '0;

    state_d        = state_q;
    to_d           = to_q;
    st_d           = st_q;
    pa_d           = a_pos;
    pb_d           = b_pos;
    pc_d           = c_pos;
    sym_a_d        = sym_a_q;
    sym_b_d        = sym_b_q;
    sym_c_d        = sym_c_q;
    payout_d       = payout_q;
    spin_go_d      = 1'b0;
    result_valid_d = 1'b0;
    win_d          = 1'b0;
    no_credit_d    = 1'b0;
    add            = '0;
    sub            = '0;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (credits_q >= BET_C) begin
            spin_go_d = 1'b1;
            sub       = BET_C;
            to_d      = '0;
            state_d   = S_SPIN;
          end else begin
            no_credit_d = 1'b1;
          end
        end
      end
      S_SPIN: begin
        // Timeout covers a spin command the reel controller never acted on.
        if (moved || to_q == TO_W'(ARM_TO - 1)) begin
          st_d    = '0;
          state_d = S_SETTLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_SETTLE: begin
        if (moved) begin
          st_d = '0;
        end else if (st_q == ST_W'(SETTLE - 1)) begin
          st_d    = '0;
          state_d = S_JUDGE;
        end else begin
          st_d = st_q + ST_W'(1);
        end
      end
      S_JUDGE: begin
        sym_a_d        = qa;
        sym_b_d        = qb;
        sym_c_d        = qc;
        payout_d       = score;
        add            = score;
        result_valid_d = 1'b1;
        win_d          = (score != '0);
        state_d        = S_PAY;
      end
      S_PAY:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Coin, bet and payout are netted in one update; a bet never underflows.
    sum = {2'b00, credits_q} + SW'(coin_in) + {2'b00, add} - {2'b00, sub};
    credits_d = (sum > {2'b00, CMAX}) ? CMAX : sum[CREDIT_W-1:0];
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      to_q           <= '0;
      st_q           <= '0;
      pa_q           <= '0;
      pb_q           <= '0;
      pc_q           <= '0;
      credits_q      <= START_C;
      payout_q       <= '0;
      sym_a_q        <= '0;
      sym_b_q        <= '0;
      sym_c_q        <= '0;
      spin_go_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      no_credit_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      to_q           <= to_d;
      st_q           <= st_d;
      pa_q           <= pa_d;
      pb_q           <= pb_d;
      pc_q           <= pc_d;
      credits_q      <= credits_d;
      payout_q       <= payout_d;
      sym_a_q        <= sym_a_d;
      sym_b_q        <= sym_b_d;
      sym_c_q        <= sym_c_d;
      spin_go_q      <= spin_go_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
      no_credit_q    <= no_credit_d;
    end
  end

  assign spin_go      = spin_go_q;
  assign busy         = busy_q;
  assign credits      = credits_q;
  assign sym_a        = sym_a_q;
  assign sym_b        = sym_b_q;
  assign sym_c        = sym_c_q;
  assign payout       = payout_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;
  assign no_credit    = no_credit_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_reel_result_judge.sv
// Randomized bench for reel_result_judge: a behavioural model of credits, symbol
// quantization and scoring predicts every published result.
module tb_reel_result_judge;

  localparam int ROWS   = 240;
  localparam int SYM_H  = 80;
  localparam int SETTLE = 4;
  localparam int ARM_TO = 16;
  localparam int BET    = 1;
  localparam int PAY3   = 8;
  localparam int PAY2   = 2;
  localparam int CMAX   = 255;
  localparam int START  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_req = 1'b0;
  logic       coin_in = 1'b0;
  logic [9:0] a_pos = '0, b_pos = '0, c_pos = '0;
  logic       spin_go, busy, result_valid, win, no_credit;
  logic [7:0] credits, payout;
  logic [1:0] sym_a, sym_b, sym_c;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  int m_credits = START;
  int cur_a = 0, cur_b = 0, cur_c = 0;
  logic [13:0] exp_q[$];

  reel_result_judge dut (
    .clk(clk), .rst(rst), .start_req(start_req), .coin_in(coin_in),
    .a_pos(a_pos), .b_pos(b_pos), .c_pos(c_pos),
    .spin_go(spin_go), .busy(busy), .credits(credits),
    .sym_a(sym_a), .sym_b(sym_b), .sym_c(sym_c), .payout(payout),
    .result_valid(result_valid), .win(win), .no_credit(no_credit),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_sym(input int p);
    if (p >= ROWS) return ROWS / SYM_H - 1;
    return p / SYM_H;
  endfunction

  function automatic int exp_pay(input int x, input int y, input int z);
    int pairs;
    pairs = int'(x == y) + int'(y == z) + int'(x == z);
    if (pairs == 3) return PAY3;
    if (pairs >= 1) return PAY2;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic int pre_pos(input int p);
    if (p >= ROWS) return 0;
    if (p == 0) return ROWS - 1;
    return p - 1;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_pos(input int a, input int b, input int c);
    cur_a = a; cur_b = b; cur_c = c;
    a_pos = 10'(a); b_pos = 10'(b); c_pos = 10'(c);
  endtask

  task automatic coin_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      coin_in = 1'b1;
      m_credits = sat(m_credits + 1);
      tick();
    end
    coin_in = 1'b0;
  endtask

  // Start a spin, move the reels, and leave the final positions driven (cycle s).
  task automatic start_spin(input int fa, input int fb, input int fc, input int moves);
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    m_credits = m_credits - BET;
    check_eq("spin_go", spin_go, 1);
    check_eq("credits_bet", credits, m_credits);
    check_eq("busy_spin", busy, 1);
    for (int i = 0; i <= moves; i++) begin
      set_pos($urandom_range(0, ROWS - 1), $urandom_range(0, ROWS - 1), $urandom_range(0, ROWS - 1));
      tick();
      if (i == 0) check_eq("spin_go_pulse", spin_go, 0);
    end
    set_pos(pre_pos(fa), pre_pos(fb), pre_pos(fc));
    tick();
    set_pos(fa, fb, fc);
  endtask

  // Scoreboard side: expect the result exactly SETTLE+2 cycles after the last change.
  task automatic wait_result(input int coin_cyc);
    logic [13:0] e;
    int pay;
    pay = exp_pay(exp_sym(cur_a), exp_sym(cur_b), exp_sym(cur_c));
    exp_q.push_back({2'(exp_sym(cur_a)), 2'(exp_sym(cur_b)), 2'(exp_sym(cur_c)), 8'(pay)});
    for (int i = 0; i < SETTLE + 2; i++) begin
      coin_in = (i == coin_cyc);
      if (i == coin_cyc) m_credits = sat(m_credits + 1);
      tick();
      if (i < SETTLE + 1) begin
        check_eq("rv_early", result_valid, 0);
        check_eq("busy_wait", busy, 1);
      end
    end
    coin_in = 1'b0;
    check_eq("result_valid", result_valid, 1);
    e = exp_q.pop_front();
    check_eq("sym_a", sym_a, e[13:12]);
    check_eq("sym_b", sym_b, e[11:10]);
    check_eq("sym_c", sym_c, e[9:8]);
    check_eq("payout", payout, e[7:0]);
    check_eq("win", win, e[7:0] != 0);
    m_credits = sat(m_credits + int'(e[7:0]));
    check_eq("credits_pay", credits, m_credits);
    tick();
    check_eq("rv_pulse", result_valid, 0);
    check_eq("win_pulse", win, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  function automatic int rand_pos();
    if ($urandom_range(0, 3) == 0) return $urandom_range(ROWS, 1023);
    return $urandom_range(0, 2) * SYM_H + $urandom_range(0, SYM_H - 1);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int guard, seen, waited;

    tick();
    tick();
    check_eq("rst_credits", credits, START);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_spin_go", spin_go, 0);
    check_eq("rst_rv", result_valid, 0);
    check_eq("rst_win", win, 0);
    check_eq("rst_no_credit", no_credit, 0);
    check_eq("rst_payout", payout, 0);
    check_eq("rst_syms", {sym_a, sym_b, sym_c}, 0);
    rst = 1'b1;
    tick();

    // Directed line scores
    start_spin(10, 50, 20, 3);    wait_result(-1);
    start_spin(90, 170, 239, 2);  wait_result(-1);
    start_spin(0, 80, 160, 1);    wait_result(-1);

    // Jitter after three stable cycles; start_req in SETTLE is ignored
    start_spin(30, 100, 200, 2);
    tick();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    check_eq("settle_start_ignored", spin_go, 0);
    check_eq("settle_credits", credits, m_credits);
    tick();
    tick();
    check_eq("pre_jitter_rv", result_valid, 0);
    set_pos(30, 180, 200);
    wait_result(-1);

    // Randomized spins with occasional coins in IDLE
    for (int n = 0; n < 10; n++) begin
      start_spin(rand_pos(), rand_pos(), rand_pos(), $urandom_range(0, 6));
      wait_result(-1);
      if ($urandom_range(0, 1) == 1) begin
        coin_cycles(1);
        check_eq("coin_idle", credits, m_credits);
      end
    end

    // Drain credits with losing spins, then a refused start
    guard = 0;
    while (m_credits >= BET && guard < 300) begin
      start_spin(0, 80, 160, 1);
      wait_result(-1);
      guard++;
    end
    check_eq("drained", credits, 0);
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    check_eq("no_credit", no_credit, 1);
    check_eq("no_credit_spin_go", spin_go, 0);
    check_eq("no_credit_busy", busy, 0);
    check_eq("no_credit_state", state_dbg, 0);
    check_eq("no_credit_credits", credits, 0);
    tick();
    check_eq("no_credit_pulse", no_credit, 0);
    coin_cycles(1);
    check_eq("coin_one", credits, 1);
    start_spin(0, 80, 160, 1);
    wait_result(-1);

    // Saturation: coin to the ceiling, then coin together with a PAY3
    coin_cycles(260);
    check_eq("coin_sat", credits, CMAX);
    start_spin(10, 50, 20, 2);
    wait_result(5);
    check_eq("pay_coin_sat", credits, CMAX);

    // Asynchronous reset during SPIN
    set_pos(10, 50, 20);
    tick();
    tick();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    check_eq("pre_rst_spin_go", spin_go, 1);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_credits", credits, START);
    check_eq("midrst_spin_go", spin_go, 0);
    check_eq("midrst_state", state_dbg, 0);
    tick();
    rst = 1'b1;
    m_credits = START;
    tick();
    tick();

    // No motion at all: the arm timeout must still lead to a judged result
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    m_credits = m_credits - BET;
    check_eq("arm_spin_go", spin_go, 1);
    seen = 0;
    waited = 0;
    for (int i = 1; i <= ARM_TO + SETTLE + 8 && seen == 0; i++) begin
      tick();
      if (result_valid) begin
        seen = 1;
        waited = i;
      end
    end
    check_eq("arm_seen", seen, 1);
    check_eq("arm_not_early", waited >= ARM_TO, 1);
    check_eq("arm_syms", {sym_a, sym_b, sym_c}, 0);
    check_eq("arm_payout", payout, PAY3);
    m_credits = sat(m_credits + PAY3);
    check_eq("arm_credits", credits, m_credits);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reel_result_judge.md
Name: reel_result_judge

Overview:
- Game-control stage wrapped around the reel scroll controller.
- Upstream: gates the player's start request against the credit balance and issues the spin command into the reel scroll controller.
- Downstream: watches the three reel offsets that the scroll controller produces, detects when all reels have settled, quantizes each offset to a symbol index, scores the line and updates the credit balance.
- Runs on the same slow control clock as the reel scroll controller.

Parameters:
- ROWS, 240, reel strip height in rows; valid offsets are 0..ROWS-1.
- SYM_H, 80, rows per symbol; ROWS/SYM_H must be ≤ 4.
- SETTLE, 4, consecutive unchanged cycles required to declare reels stopped.
- ARM_TO, 16, cycles to wait for first reel motion before settling anyway.
- CREDIT_W, 8, credit counter width.
- START_CREDITS, 10, credit value loaded at reset.
- BET, 1, credits deducted per spin.
- PAY3, 8, payout when all three symbols match.
- PAY2, 2, payout when exactly two symbols match.

Ports:
- clk  in  1  control clock.
- rst  in  1  asynchronous, active-low reset.
- start_req  in  1  one-cycle start pulse from the debounce/one-pulse path.
- coin_in  in  1  one-cycle pulse that adds one credit.
- a_pos  in  10  reel A offset.
- b_pos  in  10  reel B offset.
- c_pos  in  10  reel C offset.
- spin_go  out  1  one-cycle spin command to the reel scroll controller.
- busy  out  1  high in every state except IDLE.
- credits  out  CREDIT_W  current balance.
- sym_a  out  2  judged symbol index, reel A.
- sym_b  out  2  judged symbol index, reel B.
- sym_c  out  2  judged symbol index, reel C.
- payout  out  CREDIT_W  payout of the last judged spin.
- result_valid  out  1  one-cycle pulse when a result is published.
- win  out  1  one-cycle pulse, coincident with result_valid, when payout > 0.
- no_credit  out  1  one-cycle pulse when a start is refused.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, credits = START_CREDITS.
  - spin_go, result_valid, win and no_credit = 0.
  - sym_a, sym_b, sym_c and payout = 0.
  - Stable and timeout counters = 0; previous-position registers = 0.
  - Reset mid-spin aborts the spin; the deducted BET is not refunded.
- All outputs are registered.
- FSM states: IDLE, SPIN, SETTLE, JUDGE, PAY.
- IDLE:
  - start_req with credits ≥ BET: spin_go = 1 next cycle (exactly one cycle), credits -= BET in the same update, go to SPIN.
  - start_req with credits < BET: no_credit = 1 next cycle, stay in IDLE, credits unchanged.
- start_req is ignored in every state other than IDLE; no queuing.
- Motion detect:
  - Position registers sample a_pos, b_pos and c_pos every cycle.
  - moved = any input differs from its registered previous value.
- SPIN:
  - The timeout counter counts from 0.
  - Go to SETTLE on the first cycle moved = 1, or when the counter reaches ARM_TO-1 (covers a refused or lost spin command).
- SETTLE:
  - The stable counter increments on each cycle with moved = 0 and clears to 0 on any moved = 1.
  - When the counter reaches SETTLE, go to JUDGE.
- JUDGE (one cycle):
  - sym_x = floor(pos_x / SYM_H), computed by a compare chain (no divider).
  - pos ≥ ROWS clamps to index ROWS/SYM_H-1.
  - Score: all three equal → PAY3; otherwise any pair equal → PAY2; else 0. Register it to payout.
- PAY (one cycle):
  - credits += payout, saturating at 2^CREDIT_W-1.
  - result_valid = 1; win = (payout != 0); return to IDLE.
- Latency:
  - start_req accepted at cycle t: spin_go and the decremented credits are visible at t+1.
  - Reel positions last change at cycle s: result_valid at s+SETTLE+2.
- coin_in:
  - Accepted in any state; +1 with saturation.
  - Coinciding with a BET deduction or a PAY addition, the net of all terms is applied in a single update, saturating high.
  - The net never goes below 0, because a deduction requires credits ≥ BET.
- sym_*, payout: hold their values until the next JUDGE.
- Wrap-around: a reel wrapping from ROWS-1 to 0 counts as motion, like any other change.

Test Plan:
- Reset with rst low, then release:
  - credits = 10, busy = 0, all pulse outputs 0.
  - start_req pulse → spin_go single cycle at t+1, credits = 9, busy = 1.
- Spin with moving positions, then freeze at a=10, b=50, c=20:
  - result_valid at freeze+6.
  - sym = 0/0/0, payout = 8, win = 1, credits = 17.
- Freeze at a=90, b=170, c=239:
  - sym = 1/2/2, payout = 2, win = 1.
  - A second freeze at a=0, b=80, c=160 → sym = 0/1/2, payout = 0, win = 0, credits unchanged.
- Positions jitter once after 3 stable cycles:
  - The stable counter restarts; result_valid comes SETTLE+2 cycles after the jitter.
  - start_req during SETTLE is ignored: no spin_go, credits unchanged.
- Force credits = 0 via repeated losing spins, then start_req:
  - no_credit pulse, no spin_go, state stays IDLE.
  - coin_in → credits = 1; the next start is accepted.
- Credits = 254 (CREDIT_W=8), coin_in coincident with PAY of 8 → credits = 255 (saturated).
  - rst asserted mid-SPIN → immediate IDLE, credits = 10, spin_go = 0.
  - No spin_go within ARM_TO and no motion → SETTLE, then JUDGE on the static positions.
